// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; unused opcodes produce zero, ADD/SUB wrap silently.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // NOTE: result gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (op)
      OPCODE_LENGTH'(ALU_AND): result = a & b;
      OPCODE_LENGTH'(ALU_OR):  result = a | b;
      OPCODE_LENGTH'(ALU_ADD): result = a + b;
      OPCODE_LENGTH'(ALU_SUB): result = a - b;
      OPCODE_LENGTH'(ALU_XOR): result = a ^ b;
      OPCODE_LENGTH'(ALU_SLL): result = a << shamt;
      OPCODE_LENGTH'(ALU_SRL): result = a >> shamt;
      OPCODE_LENGTH'(ALU_SLT): result = DATA_WIDTH'(a < b);
      OPCODE_LENGTH'(ALU_EQ):  result = DATA_WIDTH'(a == b);
      default:                 result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU; a round-robin grant feeds a single-entry result
// register that can be refilled in the same cycle it drains.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);

  state_t                   state, state_nxt;
  logic                     last_grant;
  logic                     id_q;
  logic [DATA_WIDTH-1:0]    a_q, b_q;
  logic [OPCODE_LENGTH-1:0] op_q;

  logic accept_en, grant_valid, grant_id, accept;

  always_comb begin
    state_nxt   = state;
    // Ready is gated by rst_n so no requester sees ready while reset is held.
    accept_en   = rst_n && ((state == ST_IDLE) || rsp_ready);
    grant_valid = req0_valid || req1_valid;
    grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept      = accept_en && grant_valid;
    req0_ready  = accept && !grant_id;
    req1_ready  = accept && grant_id;

    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HOLD;
      ST_HOLD: if (!accept && rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      a_q        <= grant_id ? req1_a  : req0_a;
      b_q        <= grant_id ? req1_b  : req0_b;
      op_q       <= grant_id ? req1_op : req0_op;
      id_q       <= grant_id;
      last_grant <= grant_id;
    end
  end

  assign rsp_valid = (state == ST_HOLD);
  assign rsp_id    = id_q;

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(rsp_result)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: opcode vector table, directed handshake sequences and a
// randomized run scored against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;

  // Reference model: what is held, for whom, and who won the last grant.
  bit          m_held;
  bit          m_id;
  logic [31:0] m_res;
  int          m_last;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return a << (b % 32);
      4'd6:    return a >> (b % 32);
      4'd7:    return (a < b) ? 32'd1 : 32'd0;
      4'd8:    return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_held = 0;
    m_id   = 0;
    m_res  = '0;
    m_last = 1;
  endtask

  // One clock of traffic: check held response, drive, check readies, then clock.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1,
                      input logic rr);
    int g;
    @(negedge clk);
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_held});
    if (m_held) begin
      check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      check("rsp_result", rsp_result, m_res);
    end
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready  = rr;
    #1;
    g = -1;
    if (!m_held || rr) begin
      if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end
    check("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    @(posedge clk);
    if (g >= 0) begin
      m_held = 1;
      m_id   = (g == 1);
      m_res  = (g == 0) ? ref_alu(o0, a0, b0) : ref_alu(o1, a1, b1);
      m_last = g;
    end else if (m_held && rr) begin
      m_held = 0;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready  = 0;
  endtask

  // Holds reset with req0 asserting valid, checks reset values, releases just after an edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    req0_valid = 1;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[1]  = '{4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF};
    vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[3]  = '{4'b0011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[4]  = '{4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    vecs[5]  = '{4'b0101, 32'h00000001, 32'd33,       32'h00000002};
    vecs[6]  = '{4'b0110, 32'h80000000, 32'd31,       32'h00000001};
    vecs[7]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[8]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    vecs[9]  = '{4'b1000, 32'h00001234, 32'h00001234, 32'h00000001};
    vecs[10] = '{4'b1000, 32'h00001234, 32'h00001235, 32'h00000000};
    vecs[11] = '{4'b1111, 32'h00000005, 32'h00000007, 32'h00000000};
    vecs[12] = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    idle_inputs();
    model_reset();
    do_reset();

    // First accept on the first edge after reset release.
    step(1, 32'd5, 32'd7, 4'b0010, 0, '0, '0, '0, 1);
    #1;
    check("first_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("first_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("first_rsp_result", rsp_result, 32'd12);

    // Opcode table, back to back through requester 0.
    for (int i = 0; i < 13; i++) begin
      step(1, vecs[i].a, vecs[i].b, vecs[i].op, 0, '0, '0, '0, 1);
      #1;
      check($sformatf("vec%0d_result", i), rsp_result, vecs[i].exp);
    end

    // Continuous contention alternates grants starting with requester 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'd10, 32'd3, 4'b0011, 1, 32'hF0, 32'h0F, 4'b0100, 1);
      #1;
      check($sformatf("rr%0d_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("rr%0d_result", i), rsp_result, (i % 2 == 0) ? 32'd7 : 32'hFF);
    end

    // Backpressure: response held stable, req1 waits, then goes with no gap.
    step(1, 32'd100, 32'd1, 4'b0010, 0, '0, '0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, '0, '0, 1, 32'd3, 32'd4, 4'b0010, 0);
      #1;
      check("bp_hold_result", rsp_result, 32'd101);
    end
    step(0, '0, '0, '0, 1, 32'd3, 32'd4, 4'b0010, 1);
    #1;
    check("bp_release_id", {31'd0, rsp_id}, 32'd1);
    check("bp_release_result", rsp_result, 32'd7);

    // Asynchronous reset while holding a result.
    step(0, '0, '0, '0, 0, '0, '0, '0, 0);
    #3 rst_n = 0;
    #1;
    check("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("async_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    do_reset();
    step(1, 32'd1, 32'd1, 4'b0010, 1, 32'd9, 32'd9, 4'b0010, 1);
    #1;
    check("post_rst_tie_id", {31'd0, rsp_id}, 32'd0);
    check("post_rst_tie_result", rsp_result, 32'd2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 40), 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
